// File: rtl/audio_pkg.sv
// Shared audio-path definitions: period limits, default playback speed,
// handshake state encoding and the period clamp helper.
package audio_pkg;

   localparam logic [31:0] DEFAULT_MIN_COUNT = 32'd16;
   localparam logic [31:0] DEFAULT_MAX_COUNT = 32'd65535;
   localparam logic [31:0] DEFAULT_SPEED     = 32'd2274;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } req_state_t;

   // Upstream wraps (to 0 or to huge values) land on the nearest legal period.
   function automatic logic [31:0] clamp_period(input logic [31:0] x,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
      logic [31:0] y;
      y = x;
      if (x < lo)
         y = lo;
      else if (x > hi)
         y = hi;
      return y;
   endfunction

endpackage

// File: rtl/sample_rate_gen_if.sv
// Sample request/acknowledge handshake between the rate generator and the
// flash-read/audio consumer.
interface sample_rate_gen_if;
   logic sample_req;
   logic sample_ack;

   modport master (output sample_req, input sample_ack);
   modport slave  (input sample_req, output sample_ack);
endinterface

// File: rtl/period_counter.sv
// Period counter: clamps the requested period, holds the period in force and
// raises a combinational tick on the last cycle of each period.
module period_counter
   import audio_pkg::*;
#(
   parameter logic [31:0] MIN_COUNT = DEFAULT_MIN_COUNT,
   parameter logic [31:0] MAX_COUNT = DEFAULT_MAX_COUNT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] count_to,
   output logic [31:0] limit,
   output logic        tick
);

   logic [31:0] r_cnt;
   logic [31:0] r_limit;
   logic [31:0] w_clamped;
   logic        w_tick;

   assign w_clamped = clamp_period(count_to, MIN_COUNT, MAX_COUNT);
   assign w_tick    = enable && (r_cnt == (r_limit - 32'd1));

   // The new period is only taken at the wrap, so mid-period edits never
   // shorten or stretch the period already running.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 32'd0;
         r_limit <= w_clamped;
      end else if (w_tick) begin
         r_cnt   <= 32'd0;
         r_limit <= w_clamped;
      end else if (enable) begin
         r_cnt   <= r_cnt + 32'd1;
      end
   end

   assign limit = r_limit;
   assign tick  = w_tick;

endmodule

// File: rtl/sample_rate_gen.sv
// Audio sample-rate strobe generator: divides clk into sample requests
// delivered over a req/ack handshake, flagging requests lost to a slow consumer.
module sample_rate_gen
   import audio_pkg::*;
#(
   parameter logic [31:0] MIN_COUNT = DEFAULT_MIN_COUNT,
   parameter logic [31:0] MAX_COUNT = DEFAULT_MAX_COUNT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [31:0]               count_to,
   input  logic                      overrun_clr,
   sample_rate_gen_if.master         hs,
   output logic                      overrun,
   output logic [31:0]               limit
);

   logic       w_tick;
   req_state_t r_state;
   req_state_t w_state_next;
   logic       w_overrun_set;
   logic       r_overrun;

   period_counter #(
      .MIN_COUNT(MIN_COUNT),
      .MAX_COUNT(MAX_COUNT)
   ) u_period_counter (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .count_to (count_to),
      .limit    (limit),
      .tick     (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_overrun_set)
            r_overrun <= 1'b1;
         else if (overrun_clr)
            r_overrun <= 1'b0;
      end
   end

   // A tick while still pending re-arms the request; it is only an overrun
   // if the consumer did not take the old sample in that same cycle.
   always_comb begin
      w_state_next  = r_state;
      w_overrun_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick)
               w_state_next = REQ;
         end
         REQ: begin
            if (w_tick) begin
               w_state_next  = REQ;
               w_overrun_set = !hs.sample_ack;
            end else if (hs.sample_ack) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign hs.sample_req = (r_state == REQ);
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_sample_rate_gen.sv
// Directed bench for sample_rate_gen: expected request edges and limits go into
// a scoreboard queue, a negedge monitor pops and compares each request rise.
module tb_sample_rate_gen;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] count_to;
   logic        overrun_clr;
   logic        overrun;
   logic [31:0] limit;

   sample_rate_gen_if srg_if ();

   sample_rate_gen #(
      .MIN_COUNT(32'd16),
      .MAX_COUNT(32'd65535)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .count_to    (count_to),
      .overrun_clr (overrun_clr),
      .hs          (srg_if),
      .overrun     (overrun),
      .limit       (limit)
   );

   typedef struct {
      int          edge_n;
      logic [31:0] lim;
   } exp_t;

   exp_t q[$];
   int   ec = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   auto_ack = 1'b1;
   int   ack_edge = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) ec <= ec + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, ec, act, exp);
   endtask

   task automatic push(input int e, input logic [31:0] l);
      exp_t x;
      x.edge_n = e;
      x.lim    = l;
      q.push_back(x);
   endtask

   task automatic wait_until(input int e);
      while (ec < e) @(negedge clk);
   endtask

   // Consumer model: prompt ack one cycle after a request, or a single ack
   // aimed at a chosen edge.
   initial begin
      srg_if.sample_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (auto_ack)
            srg_if.sample_ack = srg_if.sample_req && !srg_if.sample_ack;
         else
            srg_if.sample_ack = ((ec + 1) == ack_edge);
      end
   end

   // Monitor: each rising request must match the head of the scoreboard.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (srg_if.sample_req && !prev) begin
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_req at edge %0d: got a request, expected none", ec);
            end else begin
               e = q.pop_front();
               chk("req_rise_edge", ec, e.edge_n);
               chk("req_rise_limit", limit, e.lim);
               $display("req rise at edge %0d limit %0d (expected edge %0d limit %0d)",
                        ec, limit, e.edge_n, e.lim);
            end
         end
         prev = srg_if.sample_req;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d, expected finish", ec);
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      enable      = 1'b1;
      count_to    = 32'd2274;
      overrun_clr = 1'b0;
      push(2275, 32'd2274);
      push(4549, 32'd2274);
      push(6823, 32'd2290);

      @(negedge clk);
      chk("reset_req", srg_if.sample_req, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_limit", limit, 32'd2274);
      reset = 1'b0;

      // Mid-period speed change takes effect only at the wrap.
      wait_until(4549 + 1000);
      count_to = 32'd2290;
      wait_until(6822);
      chk("limit_before_wrap", limit, 32'd2274);

      // Clamp boundaries: 0 -> 16, huge -> 65535, 16 -> 16.
      push(9113, 32'd16);
      wait_until(6823);
      count_to = 32'd0;
      push(9129, 32'd65535);
      wait_until(9113);
      count_to = 32'hFFFF_FFF0;
      push(74664, 32'd16);
      wait_until(9129);
      count_to = 32'd16;
      push(74680, 32'd16);
      push(74696, 32'd16);

      // Consumer stops acking: overrun on the second tick.
      wait_until(74680);
      auto_ack = 1'b0;
      wait_until(74711);
      chk("overrun_before_tick2", overrun, 0);
      chk("req_pending", srg_if.sample_req, 1);
      wait_until(74712);
      chk("overrun_set", overrun, 1);
      chk("req_still_high", srg_if.sample_req, 1);
      overrun_clr = 1'b1;
      wait_until(74713);
      chk("overrun_cleared", overrun, 0);
      overrun_clr = 1'b0;
      wait_until(74727);
      overrun_clr = 1'b1;
      wait_until(74728);
      chk("overrun_set_beats_clr", overrun, 1);
      wait_until(74729);
      chk("overrun_cleared_again", overrun, 0);
      overrun_clr = 1'b0;

      // Ack lands on the tick edge: new sample pending, no overrun.
      ack_edge = 74744;
      push(74760, 32'd16);
      wait_until(74744);
      chk("ack_on_tick_req", srg_if.sample_req, 1);
      chk("ack_on_tick_overrun", overrun, 0);
      auto_ack = 1'b1;
      wait_until(74746);
      chk("req_after_ack", srg_if.sample_req, 0);

      // Enable low for 100 cycles stretches the period by 100.
      push(74876, 32'd16);
      wait_until(74765);
      enable = 1'b0;
      wait_until(74865);
      enable = 1'b1;

      // Reset while a request is pending and overrun is set.
      push(74892, 32'd16);
      wait_until(74876);
      auto_ack = 1'b0;
      wait_until(74908);
      chk("pre_reset_req", srg_if.sample_req, 1);
      chk("pre_reset_overrun", overrun, 1);
      reset    = 1'b1;
      count_to = 32'd100;
      wait_until(74909);
      chk("midreq_reset_req", srg_if.sample_req, 0);
      chk("midreq_reset_overrun", overrun, 0);
      chk("midreq_reset_limit", limit, 32'd100);
      reset    = 1'b0;
      auto_ack = 1'b1;
      push(75009, 32'd100);

      wait_until(75012);
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
